// File: rtl/regfile_arb_pkg.sv
// Shared constants and transaction type for the register-file port arbiter.
package regfile_arb_pkg;

    localparam int DW = 8;
    localparam int AW = 3;

    localparam logic CLI_C0 = 1'b0;
    localparam logic CLI_C1 = 1'b1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
    } rf_txn_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic with a single priority flop.
// FAIR != 0 alternates the preferred client after every accepted transaction;
// FAIR == 0 always prefers c0. No grant is issued while reset is asserted,
// so a transaction presented during reset never reaches the register file.
module rr_arbiter2
    import regfile_arb_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic prio_q;
    logic prio_d;

    // Grant a lone requester; on contention the prio client wins, then hand prio to the other client
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        prio_d = prio_q;
        if (rst_n) begin
            if (req0 && req1) begin
                if ((FAIR != 0) && (prio_q == CLI_C1)) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        if ((FAIR != 0) && gnt0) begin
            prio_d = CLI_C1;
        end else if ((FAIR != 0) && gnt1) begin
            prio_d = CLI_C0;
        end
    end

    // Priority register, c0 preferred out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= CLI_C0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file's write port and two read ports between the
// datapath (c0) and the debug/switch loader (c1). One transaction per cycle;
// read data is captured one cycle after acceptance into per-client registers.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DW   = regfile_arb_pkg::DW,
    parameter int AW   = regfile_arb_pkg::AW,
    parameter int FAIR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c0_req,
    input  logic          c0_we,
    input  logic [AW-1:0] c0_wa,
    input  logic [DW-1:0] c0_wd,
    input  logic [AW-1:0] c0_ra1,
    input  logic [AW-1:0] c0_ra2,
    input  logic          c1_req,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_wa,
    input  logic [DW-1:0] c1_wd,
    input  logic [AW-1:0] c1_ra1,
    input  logic [AW-1:0] c1_ra2,
    output logic          c0_gnt,
    output logic          c1_gnt,
    output logic          c0_rvalid,
    output logic [DW-1:0] c0_rd1,
    output logic [DW-1:0] c0_rd2,
    output logic          c1_rvalid,
    output logic [DW-1:0] c1_rd1,
    output logic [DW-1:0] c1_rd2,
    output logic          rf_we3,
    output logic [AW-1:0] rf_wa3,
    output logic [DW-1:0] rf_wd3,
    output logic [AW-1:0] rf_ra1,
    output logic [AW-1:0] rf_ra2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2
);

    rf_txn_t       sel_txn;
    logic          c0_rvalid_q, c0_rvalid_d;
    logic          c1_rvalid_q, c1_rvalid_d;
    logic [DW-1:0] c0_rd1_q, c0_rd1_d, c0_rd2_q, c0_rd2_d;
    logic [DW-1:0] c1_rd1_q, c1_rd1_d, c1_rd2_q, c1_rd2_d;

    rr_arbiter2 #(
        .FAIR (FAIR)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (c0_req),
        .req1  (c1_req),
        .gnt0  (c0_gnt),
        .gnt1  (c1_gnt)
    );

    // Steer the granted client's fields onto the register file; idle drives all zeros
    always_comb begin
        sel_txn = '0;
        if (c0_gnt) begin
            sel_txn = '{we: c0_we, wa: c0_wa, wd: c0_wd, ra1: c0_ra1, ra2: c0_ra2};
        end else if (c1_gnt) begin
            sel_txn = '{we: c1_we, wa: c1_wa, wd: c1_wd, ra1: c1_ra1, ra2: c1_ra2};
        end
    end

    assign rf_we3 = sel_txn.we;
    assign rf_wa3 = sel_txn.wa;
    assign rf_wd3 = sel_txn.wd;
    assign rf_ra1 = sel_txn.ra1;
    assign rf_ra2 = sel_txn.ra2;

    // Capture read data for the accepted client; other client's data holds, its valid drops
    always_comb begin
        c0_rvalid_d = c0_gnt;
        c1_rvalid_d = c1_gnt;
        c0_rd1_d    = c0_gnt ? rf_rd1 : c0_rd1_q;
        c0_rd2_d    = c0_gnt ? rf_rd2 : c0_rd2_q;
        c1_rd1_d    = c1_gnt ? rf_rd1 : c1_rd1_q;
        c1_rd2_d    = c1_gnt ? rf_rd2 : c1_rd2_q;
    end

    // Response registers; reset drops any in-flight response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_rvalid_q <= 1'b0;
            c1_rvalid_q <= 1'b0;
            c0_rd1_q    <= '0;
            c0_rd2_q    <= '0;
            c1_rd1_q    <= '0;
            c1_rd2_q    <= '0;
        end else begin
            c0_rvalid_q <= c0_rvalid_d;
            c1_rvalid_q <= c1_rvalid_d;
            c0_rd1_q    <= c0_rd1_d;
            c0_rd2_q    <= c0_rd2_d;
            c1_rd1_q    <= c1_rd1_d;
            c1_rd2_q    <= c1_rd2_d;
        end
    end

    assign c0_rvalid = c0_rvalid_q;
    assign c1_rvalid = c1_rvalid_q;
    assign c0_rd1    = c0_rd1_q;
    assign c0_rd2    = c0_rd2_q;
    assign c1_rd1    = c1_rd1_q;
    assign c1_rd2    = c1_rd2_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: a round-robin instance plus a fixed-priority
// instance, an 8x8 register file model, and a transaction-level reference model.
module tb_regfile_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    logic       cReq [2];
    logic       cWe  [2];
    logic [2:0] cWa  [2];
    logic [7:0] cWd  [2];
    logic [2:0] cRa1 [2];
    logic [2:0] cRa2 [2];

    logic       c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [7:0] c0_rd1, c0_rd2, c1_rd1, c1_rd2;
    logic       rf_we3;
    logic [2:0] rf_wa3, rf_ra1, rf_ra2;
    logic [7:0] rf_wd3, rf_rd1, rf_rd2;

    logic       fp_c0_gnt, fp_c1_gnt, fp_c0_rvalid, fp_c1_rvalid;
    logic [7:0] fp_c0_rd1, fp_c0_rd2, fp_c1_rd1, fp_c1_rd2;
    logic       fp_rf_we3;
    logic [2:0] fp_rf_wa3, fp_rf_ra1, fp_rf_ra2;
    logic [7:0] fp_rf_wd3, fp_rf_rd1, fp_rf_rd2;

    // Register file seen by the round-robin instance: R0 reads 0, writes to R0 dropped
    logic [7:0] rfMem [8] = '{8{8'h00}};

    always @(posedge clk) begin
        if (rf_we3 && rf_wa3 != 3'd0) rfMem[rf_wa3] <= rf_wd3;
    end

    assign rf_rd1    = (rf_ra1 == 3'd0) ? 8'h00 : rfMem[rf_ra1];
    assign rf_rd2    = (rf_ra2 == 3'd0) ? 8'h00 : rfMem[rf_ra2];
    assign fp_rf_rd1 = (fp_rf_ra1 == 3'd0) ? 8'h00 : rfMem[fp_rf_ra1];
    assign fp_rf_rd2 = (fp_rf_ra2 == 3'd0) ? 8'h00 : rfMem[fp_rf_ra2];

    regfile_port_arbiter #(.DW(8), .AW(3), .FAIR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(cReq[0]), .c0_we(cWe[0]), .c0_wa(cWa[0]), .c0_wd(cWd[0]),
        .c0_ra1(cRa1[0]), .c0_ra2(cRa2[0]),
        .c1_req(cReq[1]), .c1_we(cWe[1]), .c1_wa(cWa[1]), .c1_wd(cWd[1]),
        .c1_ra1(cRa1[1]), .c1_ra2(cRa2[1]),
        .c0_gnt(c0_gnt), .c1_gnt(c1_gnt),
        .c0_rvalid(c0_rvalid), .c0_rd1(c0_rd1), .c0_rd2(c0_rd2),
        .c1_rvalid(c1_rvalid), .c1_rd1(c1_rd1), .c1_rd2(c1_rd2),
        .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
    );

    regfile_port_arbiter #(.DW(8), .AW(3), .FAIR(0)) dutFixed (
        .clk(clk), .rst_n(rst_n),
        .c0_req(cReq[0]), .c0_we(cWe[0]), .c0_wa(cWa[0]), .c0_wd(cWd[0]),
        .c0_ra1(cRa1[0]), .c0_ra2(cRa2[0]),
        .c1_req(cReq[1]), .c1_we(cWe[1]), .c1_wa(cWa[1]), .c1_wd(cWd[1]),
        .c1_ra1(cRa1[1]), .c1_ra2(cRa2[1]),
        .c0_gnt(fp_c0_gnt), .c1_gnt(fp_c1_gnt),
        .c0_rvalid(fp_c0_rvalid), .c0_rd1(fp_c0_rd1), .c0_rd2(fp_c0_rd2),
        .c1_rvalid(fp_c1_rvalid), .c1_rd1(fp_c1_rd1), .c1_rd2(fp_c1_rd2),
        .rf_we3(fp_rf_we3), .rf_wa3(fp_rf_wa3), .rf_wd3(fp_rf_wd3),
        .rf_ra1(fp_rf_ra1), .rf_ra2(fp_rf_ra2), .rf_rd1(fp_rf_rd1), .rf_rd2(fp_rf_rd2)
    );

    // Reference model state: whose turn it is on contention, register contents, expected responses
    int         checks = 0;
    int         failures = 0;
    int         turn;
    logic [7:0] mRegs    [8];
    logic       expValid [2];
    logic [7:0] expRd1   [2];
    logic [7:0] expRd2   [2];
    bit         accepted [2];
    bit         pending  [2];
    logic       obsG0, obsG1, obsFpG0, obsWe;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mRead(input logic [2:0] a);
        return (a == 3'd0) ? 8'h00 : mRegs[a];
    endfunction

    task automatic modelReset();
        turn = 0;
        for (int i = 0; i < 2; i++) begin
            expValid[i] = 1'b0;
            expRd1[i]   = 8'h00;
            expRd2[i]   = 8'h00;
        end
    endtask

    // One clock cycle: inputs already driven; check, advance the model, move to next negedge
    task automatic applyStimulus(input bit midReset);
        logic eg [2];
        int   w;
        #1;
        checkOutput("c0_rvalid", 8'(c0_rvalid), 8'(expValid[0]));
        checkOutput("c1_rvalid", 8'(c1_rvalid), 8'(expValid[1]));
        checkOutput("c0_rd1", c0_rd1, expRd1[0]);
        checkOutput("c0_rd2", c0_rd2, expRd2[0]);
        checkOutput("c1_rd1", c1_rd1, expRd1[1]);
        checkOutput("c1_rd2", c1_rd2, expRd2[1]);

        eg[0] = 1'b0;
        eg[1] = 1'b0;
        if (rst_n) begin
            if (cReq[0] && cReq[1]) begin
                eg[0] = (turn == 0);
                eg[1] = (turn == 1);
            end else begin
                eg[0] = cReq[0];
                eg[1] = cReq[1];
            end
        end
        obsG0   = c0_gnt;
        obsG1   = c1_gnt;
        obsFpG0 = fp_c0_gnt;
        obsWe   = rf_we3;
        checkOutput("c0_gnt", 8'(c0_gnt), 8'(eg[0]));
        checkOutput("c1_gnt", 8'(c1_gnt), 8'(eg[1]));
        checkOutput("fixed_c0_gnt", 8'(fp_c0_gnt), 8'(rst_n && cReq[0]));
        checkOutput("fixed_c1_gnt", 8'(fp_c1_gnt), 8'(rst_n && cReq[1] && !cReq[0]));

        w = eg[0] ? 0 : (eg[1] ? 1 : -1);
        if (w < 0) begin
            checkOutput("rf_we3_idle", 8'(rf_we3), 8'h00);
            checkOutput("rf_wa3_idle", 8'(rf_wa3), 8'h00);
            checkOutput("rf_wd3_idle", rf_wd3, 8'h00);
            checkOutput("rf_ra1_idle", 8'(rf_ra1), 8'h00);
            checkOutput("rf_ra2_idle", 8'(rf_ra2), 8'h00);
        end else begin
            checkOutput("rf_we3", 8'(rf_we3), 8'(cWe[w]));
            checkOutput("rf_wa3", 8'(rf_wa3), 8'(cWa[w]));
            checkOutput("rf_wd3", rf_wd3, cWd[w]);
            checkOutput("rf_ra1", 8'(rf_ra1), 8'(cRa1[w]));
            checkOutput("rf_ra2", 8'(rf_ra2), 8'(cRa2[w]));
        end

        accepted[0] = eg[0];
        accepted[1] = eg[1];
        if (midReset) begin
            #2 rst_n = 1'b0;
        end else if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                expValid[i] = eg[i];
                if (eg[i]) begin
                    expRd1[i] = mRead(cRa1[i]);
                    expRd2[i] = mRead(cRa2[i]);
                end
            end
            if (w >= 0) begin
                if (cWe[w] && cWa[w] != 3'd0) mRegs[cWa[w]] = cWd[w];
                turn = 1 - w;
            end
        end
        if (!rst_n) modelReset();
        @(negedge clk);
    endtask

    // Single-client transaction, bounded wait for acceptance
    task automatic doTxn(input int c, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] ra1, input logic [2:0] ra2);
        bit done = 0;
        cReq[1-c] = 1'b0;
        cReq[c] = 1'b1; cWe[c] = we; cWa[c] = wa; cWd[c] = wd; cRa1[c] = ra1; cRa2[c] = ra2;
        for (int n = 0; n < 4 && !done; n++) begin
            applyStimulus(1'b0);
            done = accepted[c];
        end
        if (!done) checkOutput("txn_accept_timeout", 8'h00, 8'h01);
        cReq[c] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            cReq[i] = 0; cWe[i] = 0; cWa[i] = 0; cWd[i] = 0; cRa1[i] = 0; cRa2[i] = 0;
            pending[i] = 0;
        end
        for (int r = 0; r < 8; r++) mRegs[r] = 8'h00;
        modelReset();
        rst_n = 1'b0;
        repeat (2) applyStimulus(1'b0);
        rst_n = 1'b1;

        // Write R3 then read it back
        doTxn(0, 1'b1, 3'd3, 8'hA5, 3'd0, 3'd0);
        checkOutput("t1_gnt", 8'(obsG0), 8'h01);
        checkOutput("t1_we3", 8'(obsWe), 8'h01);
        doTxn(0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd0);
        checkOutput("t1_rvalid", 8'(c0_rvalid), 8'h01);
        checkOutput("t1_rd1", c0_rd1, 8'hA5);

        // Write to R0 is discarded
        doTxn(1, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0);
        doTxn(1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd3);
        checkOutput("t3_rd1_r0", c1_rd1, 8'h00);
        checkOutput("t3_rd2_r3", c1_rd2, 8'hA5);

        // Read-during-write returns the old value
        doTxn(0, 1'b1, 3'd5, 8'h22, 3'd0, 3'd0);
        doTxn(0, 1'b1, 3'd5, 8'h11, 3'd5, 3'd5);
        checkOutput("t4_rd1_old", c0_rd1, 8'h22);
        checkOutput("t4_rd2_old", c0_rd2, 8'h22);
        doTxn(0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd0);
        checkOutput("t4_rd1_new", c0_rd1, 8'h11);

        // Idle cycles: nothing driven, prio (now c1 after the c0 accept) holds
        repeat (3) begin
            applyStimulus(1'b0);
            checkOutput("t5_rvalid0", 8'(c0_rvalid), 8'h00);
        end
        checkOutput("t5_rf_ra1", 8'(rf_ra1), 8'h00);
        cReq[0] = 1; cWe[0] = 0; cRa1[0] = 3'd3;
        cReq[1] = 1; cWe[1] = 0; cRa1[1] = 3'd5;
        applyStimulus(1'b0);
        checkOutput("t5_prio_held_c1", 8'(obsG1), 8'h01);
        cReq[1] = 0;
        applyStimulus(1'b0);
        checkOutput("t5_c0_next", 8'(obsG0), 8'h01);
        cReq[0] = 0;

        // Reset between accept and edge: response dropped, write lost
        cReq[0] = 1; cWe[0] = 1; cWa[0] = 3'd6; cWd[0] = 8'h77; cRa1[0] = 3'd5; cRa2[0] = 3'd3;
        applyStimulus(1'b1);
        checkOutput("t6_rvalid", 8'(c0_rvalid), 8'h00);
        checkOutput("t6_rd1", c0_rd1, 8'h00);
        checkOutput("t6_rd2", c0_rd2, 8'h00);
        cReq[0] = 0;
        applyStimulus(1'b0);
        rst_n = 1'b1;

        // Continuous contention straight out of reset
        for (int k = 0; k < 4; k++) begin
            cReq[0] = 1; cWe[0] = 0; cRa1[0] = 3'd3;
            cReq[1] = 1; cWe[1] = 0; cRa1[1] = 3'd5;
            applyStimulus(1'b0);
            checkOutput("t2_fair_c0", 8'(obsG0), 8'((k % 2) == 0));
            checkOutput("t2_fixed_c0", 8'(obsFpG0), 8'h01);
        end
        cReq[0] = 0; cReq[1] = 0;
        doTxn(0, 1'b0, 3'd0, 8'h00, 3'd6, 3'd0);
        checkOutput("t6_write_lost", c0_rd1, 8'h00);

        // Random traffic obeying the hold-until-grant rule
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pending[i] && $urandom_range(0, 2) != 0) begin
                    pending[i] = 1;
                    cWe[i]  = 1'($urandom_range(0, 1));
                    cWa[i]  = 3'($urandom_range(0, 7));
                    cWd[i]  = 8'($urandom_range(0, 255));
                    cRa1[i] = 3'($urandom_range(0, 7));
                    cRa2[i] = 3'($urandom_range(0, 7));
                end
                cReq[i] = pending[i];
            end
            applyStimulus(1'b0);
            for (int i = 0; i < 2; i++) if (accepted[i]) pending[i] = 0;
        end
        cReq[0] = 0; cReq[1] = 0;
        applyStimulus(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
